// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the Writeback stage has priority, and aux results queue in a FIFO.
// A starvation counter forces a one-cycle W-stage stall so that queued aux results always drain.
//   state  | meaning
//   NORMAL | pipeline wins, and the FIFO head drains into idle slots
//   FORCE  | one-cycle slot for the FIFO head, with the W stage stalled
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_W,
  input  logic [4:0]  Rd_W,
  input  logic [63:0] Result_W,
  input  logic        Aux_Valid,
  input  logic [4:0]  Aux_Rd,
  input  logic [63:0] Aux_Data,
  output logic        Aux_Ready,
  output logic        Aux_Pending,
  output logic        Stall_WB,
  output logic        RegWrite_RF,
  output logic [4:0]  Rd_RF,
  output logic [63:0] WriteData_RF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]    mem_rd_q   [DEPTH];
  logic [4:0]    mem_rd_d   [DEPTH];
  logic [63:0]   mem_data_q [DEPTH];
  logic [63:0]   mem_data_d [DEPTH];

  logic          p_req, non_empty, aux_ready, push, pop;
  logic          stall, we;
  logic [4:0]    wr_rd;
  logic [63:0]   wr_data;

  always_comb begin
    p_req     = RegWrite_W && (Rd_W != 5'd0);
    non_empty = (count_q != '0);
    aux_ready = !rst && (count_q < CW'(DEPTH));
    // Writes to x0 are acknowledged but never stored.
    push      = Aux_Valid && aux_ready && (Aux_Rd != 5'd0);

    pop        = 1'b0;
    stall      = 1'b0;
    we         = 1'b0;
    wr_rd      = 5'd0;
    wr_data    = 64'd0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    if (!rst) begin
      case (state_q)
        ST_FORCE: begin
          stall      = 1'b1;
          pop        = non_empty;
          we         = non_empty;
          wr_rd      = mem_rd_q[rd_ptr_q];
          wr_data    = mem_data_q[rd_ptr_q];
          state_d    = ST_NORMAL;
          wait_cnt_d = '0;
        end
        default: begin
          if (p_req) begin
            we      = 1'b1;
            wr_rd   = Rd_W;
            wr_data = Result_W;
            if (non_empty) begin
              if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
                state_d    = ST_FORCE;
                wait_cnt_d = '0;
              end else begin
                wait_cnt_d = wait_cnt_q + WW'(1);
              end
            end else begin
              wait_cnt_d = '0;
            end
          end else if (non_empty) begin
            pop        = 1'b1;
            we         = 1'b1;
            wr_rd      = mem_rd_q[rd_ptr_q];
            wr_data    = mem_data_q[rd_ptr_q];
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = '0;
          end
        end
      endcase
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = Aux_Rd;
      mem_data_d[wr_ptr_q] = Aux_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  assign Aux_Ready    = aux_ready;
  assign Aux_Pending  = !rst && non_empty;
  assign Stall_WB     = stall;
  assign RegWrite_RF  = we;
  assign Rd_RF        = wr_rd;
  assign WriteData_RF = wr_data;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline Writeback stage (Result_W, which is ALU result, load data or PC+4 as chosen by ResultSrc_W);
  - an auxiliary long-latency result source (e.g. multi-cycle unit or late load return).
- Aux results queue in a small FIFO and drain into idle write-port cycles.
- A starvation counter forces a one-cycle Writeback stall so queued aux results always make progress.
- Sits between the Writeback mux / aux unit and the register file; Stall_WB feeds the hazard unit.

Parameters:
- DEPTH, 4, aux FIFO entries (power of 2, >=2)
- MAX_WAIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before a forced slot (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- RegWrite_W  in  1  pipeline write request
- Rd_W  in  5  pipeline destination register
- Result_W  in  64  pipeline writeback data
- Aux_Valid  in  1  aux result offered
- Aux_Rd  in  5  aux destination register
- Aux_Data  in  64  aux result data
- Aux_Ready  out  1  aux FIFO can accept this cycle
- Aux_Pending  out  1  FIFO non-empty
- Stall_WB  out  1  hold W stage this cycle (pipeline write deferred)
- RegWrite_RF  out  1  register-file write enable
- Rd_RF  out  5  register-file write address
- WriteData_RF  out  64  register-file write data

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous, active-high (rst).
  - rst clears the FIFO (count=0, read/write pointers=0), starvation counter=0 and state=NORMAL.
  - While rst=1, all outputs are forced to 0: Aux_Ready=0, Aux_Pending=0, Stall_WB=0, RegWrite_RF=0, Rd_RF=0, WriteData_RF=0.
  - Reset mid-operation discards queued entries; this is not an error.
- Request qualification:
  - Pipeline request P = RegWrite_W && Rd_W!=0. A write to x0 never occupies the port.
  - Aux handshake: transfer when Aux_Valid && Aux_Ready.
  - Aux_Ready = !rst && count<DEPTH, from registered count only. No same-cycle enqueue into a full FIFO even if a dequeue happens in that cycle.
  - An accepted aux transfer with Aux_Rd==0 is dropped: acknowledged but not stored.
- Write-port selection (combinational, zero latency, same cycle as the request):
  - FORCE state: grant aux head. Stall_WB=1. The pipeline write is not performed; the W stage holds and re-presents it next cycle.
  - Else if P: grant pipeline. RegWrite_RF=1, Rd_RF=Rd_W, WriteData_RF=Result_W.
  - Else if FIFO non-empty: grant head. RegWrite_RF=1, Rd_RF/WriteData_RF = head entry, pop at clock edge.
  - Else: RegWrite_RF=0, Rd_RF=0, WriteData_RF=0.
- Simultaneous push and pop are allowed: count unchanged, both pointers advance. A pop and the push of the same entry never happen in one cycle; a newly pushed entry is eligible from the next cycle.
- Pointers wrap modulo DEPTH.
- State machine (NORMAL, FORCE):
  - NORMAL:
    - If FIFO non-empty and P wins: wait counter increments.
    - If the FIFO drains or the head is granted: counter clears to 0.
    - When the counter would reach MAX_WAIT: next state is FORCE and the counter clears.
  - FORCE:
    - Lasts exactly one cycle; pops the head.
    - Entered only with FIFO non-empty, because count cannot drop without a grant.
    - Returns to NORMAL.
  - An aux push in a FORCE cycle is accepted normally.
- Ordering: no reordering within aux results. Cross-source ordering to the same Rd is the issuer's responsibility; the arbiter applies no hazard check.
- Stall_WB=1 only in FORCE; never two consecutive cycles.

Test Plan:
1. Reset then idle (no requests): all outputs 0, Aux_Ready=1 from first cycle after rst deasserts.
2. RegWrite_W=1, Rd_W=5, Result_W=AAAA_AAAA_AAAA_AAAA with FIFO empty -> same cycle RegWrite_RF=1, Rd_RF=5, WriteData_RF=AAAA...; Stall_WB=0.
3. Push aux (Rd=7, Data=BBBB_BBBB_BBBB_BBBB) with pipeline idle -> entry written next cycle (Rd_RF=7), Aux_Pending falls after pop. Push Aux_Rd=0 -> accepted, no write ever.
4. Push 4 aux entries with pipeline writing continuously -> Aux_Ready=0 after 4th push; a 5th Aux_Valid is held.
5. Starvation with MAX_WAIT=8 and the continuous pipeline writes of scenario 4 -> after 8 losing cycles, one cycle with Stall_WB=1 writes the head entry, while the pipeline Rd/Result re-presented next cycle is then written. Entries drain in FIFO order, one forced slot per 9 cycles.
6. rst asserted with 3 entries queued -> next cycle Aux_Pending=0, count=0, no stale entry written afterwards.
